microwave_ctrl: RTL and testbench

- Top-level sequencer for the microwave countdown timer chain (minute digit, seconds-tens mod-6 stage, seconds-ones stage).
- Captures keypad digits and drives the timer's active-low load and clear strobes and its enable.
- Watches the chain's zero flag and controls the magnetron and the completion beeper.
- All outputs are registered, with state changes on the rising edge of clock.

---
 rtl/microwave_pkg.sv | 24 ++
 rtl/digit_entry_reg.sv | 45 ++++
 rtl/microwave_ctrl.sv | 164 ++++++++++++++++
 tb/tb_microwave_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown sequencer.
package microwave_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_COOK  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  // Quick-start preset time 0:30.
  localparam logic [DIGIT_W-1:0] QS_MIN  = 4'd0;
  localparam logic [DIGIT_W-1:0] QS_TENS = 4'd3;
  localparam logic [DIGIT_W-1:0] QS_ONES = 4'd0;

  localparam int unsigned MAX_TENS_DEFAULT = 5;

endpackage

// File: rtl/digit_entry_reg.sv
// Three-digit keypad shift register (min, sec-tens, sec-ones) with
// synchronous zero, quick-start preset and a start-legality flag.
module digit_entry_reg
  import microwave_pkg::*;
#(
  parameter int unsigned MAX_TENS = MAX_TENS_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_zero,
  input  logic               i_preset,
  input  logic               i_shift,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_min,
  output logic [DIGIT_W-1:0] o_tens,
  output logic [DIGIT_W-1:0] o_ones,
  output logic               o_start_ok
);

  logic [DIGIT_W-1:0] r_min;
  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_ones;

  always_ff @(posedge clock) begin
    if (reset || i_zero) begin
      r_min  <= '0;
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_preset) begin
      r_min  <= QS_MIN;
      r_tens <= QS_TENS;
      r_ones <= QS_ONES;
    end else if (i_shift) begin
      r_min  <= r_tens;
      r_tens <= r_ones;
      r_ones <= i_digit;
    end
  end

  assign o_min      = r_min;
  assign o_tens     = r_tens;
  assign o_ones     = r_ones;
  assign o_start_ok = (|{r_min, r_tens, r_ones}) && (r_tens <= DIGIT_W'(MAX_TENS));

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave timer sequencer: keypad capture, timer load/clear/enable,
// magnetron and beeper control. Optional macro: QUICK_START_EN.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = 3,
  parameter int unsigned MAX_TENS    = MAX_TENS_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic               timer_loadn,
  output logic               timer_clearn,
  output logic               timer_en,
  output logic [DIGIT_W-1:0] data_min,
  output logic [DIGIT_W-1:0] data_tens,
  output logic [DIGIT_W-1:0] data_ones,
  output logic               magnetron_on,
  output logic               beep,
  output logic [2:0]         state
);

  localparam int unsigned CNT_W = (BEEP_CYCLES > 2) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_loadn;
  logic               r_clearn;
  logic               r_en;
  logic               r_mag;
  logic               r_beep;
  logic               r_guard;
  logic [CNT_W-1:0]   r_beep_cnt;

  logic               w_key_ok;
  logic               w_shift;
  logic               w_preset;
  logic               w_zero;
  logic               w_clr_pulse;
  logic               w_start_ok;

  assign w_key_ok = key_valid && (key_digit <= MAX_DIGIT);

  always_comb begin
    w_next      = r_state;
    w_shift     = 1'b0;
    w_preset    = 1'b0;
    w_clr_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_next = ST_IDLE;
`ifdef QUICK_START_EN
        end else if (start && door_closed) begin
          w_preset = 1'b1;
          w_next   = ST_LOAD;
`endif
        end else if (w_key_ok) begin
          w_shift = 1'b1;
          w_next  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // An accepted start drops a coincident key; start sees the pre-shift value.
        if (clear) begin
          w_next      = ST_IDLE;
          w_clr_pulse = 1'b1;
        end else if (start && door_closed && w_start_ok) begin
          w_next = ST_LOAD;
        end else if (w_key_ok) begin
          w_shift = 1'b1;
        end
      end
      ST_LOAD: begin
        w_next = door_closed ? ST_COOK : ST_PAUSE;
      end
      ST_COOK: begin
        if (timer_zero && !r_guard) begin
          w_next = ST_DONE;
        end else if (!door_closed) begin
          w_next = ST_PAUSE;
        end else if (clear) begin
          w_next      = ST_IDLE;
          w_clr_pulse = 1'b1;
        end else if (stop) begin
          w_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          w_next      = ST_IDLE;
          w_clr_pulse = 1'b1;
        end else if (start && door_closed) begin
          w_next = ST_COOK;
        end
      end
      ST_DONE: begin
        if (clear) begin
          w_next      = ST_IDLE;
          w_clr_pulse = 1'b1;
        end else if (r_beep_cnt == BEEP_LAST) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    w_zero = (w_next == ST_IDLE);
  end

  // Outputs are registered from the state being entered so they switch on the transition edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_loadn    <= 1'b1;
      r_clearn   <= 1'b0;
      r_en       <= 1'b0;
      r_mag      <= 1'b0;
      r_beep     <= 1'b0;
      r_guard    <= 1'b0;
      r_beep_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_loadn    <= (w_next != ST_LOAD);
      r_clearn   <= !w_clr_pulse;
      r_en       <= (w_next == ST_COOK);
      r_mag      <= (w_next == ST_COOK);
      r_beep     <= (w_next == ST_DONE);
      r_guard    <= (r_state == ST_LOAD);
      r_beep_cnt <= (r_state == ST_DONE) ? r_beep_cnt + CNT_W'(1) : '0;
    end
  end

  digit_entry_reg #(
    .MAX_TENS(MAX_TENS)
  ) u_digits (
    .clock      (clock),
    .reset      (reset),
    .i_zero     (w_zero),
    .i_preset   (w_preset),
    .i_shift    (w_shift),
    .i_digit    (key_digit),
    .o_min      (data_min),
    .o_tens     (data_tens),
    .o_ones     (data_ones),
    .o_start_ok (w_start_ok)
  );

  assign timer_loadn  = r_loadn;
  assign timer_clearn = r_clearn;
  assign timer_en     = r_en;
  assign magnetron_on = r_mag;
  assign beep         = r_beep;
  assign state        = r_state;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed self-checking bench for microwave_ctrl.
module tb_microwave_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero = 1'b0;
  logic       timer_loadn, timer_clearn, timer_en, magnetron_on, beep;
  logic [3:0] data_min, data_tens, data_ones;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  microwave_ctrl #(
    .BEEP_CYCLES(3),
    .MAX_TENS   (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .timer_loadn  (timer_loadn),
    .timer_clearn (timer_clearn),
    .timer_en     (timer_en),
    .data_min     (data_min),
    .data_tens    (data_tens),
    .data_ones    (data_ones),
    .magnetron_on (magnetron_on),
    .beep         (beep),
    .state        (state)
  );

  always #5 clock = ~clock;

  // Observation vectors: {state,min,tens,ones} and {loadn,clearn,en,mag,beep}.
  logic [14:0] sd;
  logic [4:0]  ct;
  assign sd = {state, data_min, data_tens, data_ones};
  assign ct = {timer_loadn, timer_clearn, timer_en, magnetron_on, beep};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_checks++;
    if (sd !== {3'd0, 4'd0, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", sd, {3'd0, 12'h000});
    end
    n_checks++;
    if (ct !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ct, 5'b10000);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (ct !== 5'b11000) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", ct, 5'b11000);
    end
  endtask

  task automatic test_cook_entry();
    key(4'd1);
    n_checks++;
    if (sd !== {3'd1, 4'd0, 4'd0, 4'd1}) begin
      n_fail++; $display("FAIL entry_k1: got %h expected %h", sd, {3'd1, 12'h001});
    end
    key(4'd4);
    key(4'd5);
    n_checks++;
    if (sd !== {3'd1, 4'd1, 4'd4, 4'd5}) begin
      n_fail++; $display("FAIL entry_k145: got %h expected %h", sd, {3'd1, 12'h145});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({state, ct} !== {3'd2, 5'b01000}) begin
      n_fail++; $display("FAIL load_cycle: got %h expected %h", {state, ct}, {3'd2, 5'b01000});
    end
    step();
    n_checks++;
    if ({state, ct} !== {3'd3, 5'b11110}) begin
      n_fail++; $display("FAIL cook_enter: got %h expected %h", {state, ct}, {3'd3, 5'b11110});
    end
    step();
    n_checks++;
    if ({sd, ct} !== {3'd3, 12'h145, 5'b11110}) begin
      n_fail++; $display("FAIL cook_hold: got %h expected %h", {sd, ct}, {3'd3, 12'h145, 5'b11110});
    end
  endtask

  task automatic test_door_pause();
    door_closed = 1'b0;
    step();
    n_checks++;
    if ({state, ct} !== {3'd4, 5'b11000}) begin
      n_fail++; $display("FAIL door_open_pause: got %h expected %h", {state, ct}, {3'd4, 5'b11000});
    end
    door_closed = 1'b1;
    step();
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++; $display("FAIL pause_hold: got %0d expected %0d", state, 4);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({sd, ct} !== {3'd3, 12'h145, 5'b11110}) begin
      n_fail++; $display("FAIL resume_no_reload: got %h expected %h", {sd, ct}, {3'd3, 12'h145, 5'b11110});
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if ({state, ct} !== {3'd4, 5'b11000}) begin
      n_fail++; $display("FAIL stop_pause: got %h expected %h", {state, ct}, {3'd4, 5'b11000});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if ({sd, ct} !== {3'd0, 12'h000, 5'b10000}) begin
      n_fail++; $display("FAIL pause_clear: got %h expected %h", {sd, ct}, {3'd0, 12'h000, 5'b10000});
    end
    step();
    n_checks++;
    if (ct !== 5'b11000) begin
      n_fail++; $display("FAIL clear_one_cycle: got %b expected %b", ct, 5'b11000);
    end
  endtask

  task automatic test_bad_tens();
    key(4'd12);
    n_checks++;
    if (sd !== {3'd0, 12'h000}) begin
      n_fail++; $display("FAIL idle_key_gt9: got %h expected %h", sd, {3'd0, 12'h000});
    end
    key(4'd9);
    key(4'd9);
    key(4'd15);
    n_checks++;
    if (sd !== {3'd1, 12'h099}) begin
      n_fail++; $display("FAIL entry_k99: got %h expected %h", sd, {3'd1, 12'h099});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({state, ct} !== {3'd1, 5'b11000}) begin
      n_fail++; $display("FAIL tens9_reject: got %h expected %h", {state, ct}, {3'd1, 5'b11000});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if ({sd, ct} !== {3'd0, 12'h000, 5'b10000}) begin
      n_fail++; $display("FAIL entry_clear: got %h expected %h", {sd, ct}, {3'd0, 12'h000, 5'b10000});
    end
    step();
    n_checks++;
    if (ct !== 5'b11000) begin
      n_fail++; $display("FAIL entry_clear_release: got %b expected %b", ct, 5'b11000);
    end
  endtask

  task automatic test_start_reject();
    key(4'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({sd, ct} !== {3'd1, 12'h000, 5'b11000}) begin
      n_fail++; $display("FAIL zero_time_reject: got %h expected %h", {sd, ct}, {3'd1, 12'h000, 5'b11000});
    end
    key(4'd7);
    door_closed = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    door_closed = 1'b1;
    n_checks++;
    if ({sd, ct} !== {3'd1, 12'h007, 5'b11000}) begin
      n_fail++; $display("FAIL door_open_reject: got %h expected %h", {sd, ct}, {3'd1, 12'h007, 5'b11000});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_done();
    key(4'd5);
    key(4'd9);
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (sd !== {3'd2, 12'h059}) begin
      n_fail++; $display("FAIL tens5_accept: got %h expected %h", sd, {3'd2, 12'h059});
    end
    step();
    timer_zero = 1'b1;
    step();
    n_checks++;
    if ({state, ct} !== {3'd3, 5'b11110}) begin
      n_fail++; $display("FAIL zero_guard: got %h expected %h", {state, ct}, {3'd3, 5'b11110});
    end
    step();
    timer_zero = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      n_checks++;
      if ({state, ct} !== {3'd5, 5'b11001}) begin
        n_fail++; $display("FAIL done_beep%0d: got %h expected %h", i, {state, ct}, {3'd5, 5'b11001});
      end
      step();
    end
    n_checks++;
    if ({sd, ct} !== {3'd0, 12'h000, 5'b11000}) begin
      n_fail++; $display("FAIL done_to_idle: got %h expected %h", {sd, ct}, {3'd0, 12'h000, 5'b11000});
    end
  endtask

  task automatic test_start_clear_pause();
    key(4'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++; $display("FAIL stop_to_pause: got %0d expected %0d", state, 4);
    end
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    n_checks++;
    if ({sd, ct} !== {3'd0, 12'h000, 5'b10000}) begin
      n_fail++; $display("FAIL clear_beats_start: got %h expected %h", {sd, ct}, {3'd0, 12'h000, 5'b10000});
    end
    step();
  endtask

  task automatic test_reset_cook();
    key(4'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++;
    if ({state, ct} !== {3'd3, 5'b11110}) begin
      n_fail++; $display("FAIL cook_before_reset: got %h expected %h", {state, ct}, {3'd3, 5'b11110});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({sd, ct} !== {3'd0, 12'h000, 5'b10000}) begin
      n_fail++; $display("FAIL reset_mid_cook: got %h expected %h", {sd, ct}, {3'd0, 12'h000, 5'b10000});
    end
    step();
    n_checks++;
    if ({state, ct} !== {3'd0, 5'b11000}) begin
      n_fail++; $display("FAIL reset_mid_cook_release: got %h expected %h", {state, ct}, {3'd0, 5'b11000});
    end
  endtask

  task automatic test_idle_start();
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef QUICK_START_EN
    n_checks++;
    if ({sd, ct} !== {3'd2, 12'h030, 5'b01000}) begin
      n_fail++; $display("FAIL quick_start_load: got %h expected %h", {sd, ct}, {3'd2, 12'h030, 5'b01000});
    end
    step();
    n_checks++;
    if ({state, ct} !== {3'd3, 5'b11110}) begin
      n_fail++; $display("FAIL quick_start_cook: got %h expected %h", {state, ct}, {3'd3, 5'b11110});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
`else
    n_checks++;
    if ({sd, ct} !== {3'd0, 12'h000, 5'b11000}) begin
      n_fail++; $display("FAIL idle_start_ignored: got %h expected %h", {sd, ct}, {3'd0, 12'h000, 5'b11000});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cook_entry();
    test_door_pause();
    test_bad_tens();
    test_start_reject();
    test_done();
    test_start_clear_pause();
    test_reset_cook();
    test_idle_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
